// File: rtl/alu_param_if.sv
// Bus between the datapath controller (master) and the shared sequential ALU (slave).
// A word is valid on outbus only while outbus_valid=1; END marks the last word of a result.
interface alu_param_if #(
    parameter int W = 8
);
    // Handshake: BEGIN is a single-cycle request taken only while the ALU is idle,
    // then X and Y follow on inbus in the next two cycles. Result words carry no
    // back-pressure: each cycle with outbus_valid=1 delivers one word, END on the last.
    logic         BEGIN;
    logic [1:0]   op_code;
    logic [W-1:0] inbus;
    logic [W-1:0] outbus;
    logic         outbus_valid;
    logic         END;
    logic         error;
    logic [3:0]   fsm_state;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, outbus_valid, END, error, fsm_state
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, outbus_valid, END, error, fsm_state
    );
endinterface

// File: rtl/alu_param.sv
// Sequential signed ALU: add/sub, radix-4 Booth multiply and restoring signed division,
// with operands loaded serially from inbus and results returned word by word.
module alu_param #(
    parameter int W = 8
) (
    input logic       clk,
    input logic       reset,
    alu_param_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_X, LOAD_Y, EXEC, MUL_STEP, DIV_STEP, DIV_FIX, OUT_HI, OUT_LO
    } state_t;

    state_t          state;
    logic [1:0]      opc;
    logic [W-1:0]    x, y, m, q, rem, res_lo;
    logic [W+1:0]    a;
    logic            q_m1;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    outbus_r;
    logic            valid_r, end_r, error_r;

    // Booth step: add 0, +-M or +-2M into A, then shift A:Q:Q[-1] right by two.
    logic [W+1:0]    m_ext, addend, a_sum, a_next;
    logic [2*W+2:0]  shift_in, shift_out;
    logic [W-1:0]    q_next;
    logic            qm1_next;

    always_comb begin
        m_ext = {{2{m[W-1]}}, m};
        case ({q[1:0], q_m1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        a_sum     = a + addend;
        shift_in  = {a_sum, q, q_m1};
        shift_out = {{2{shift_in[2*W+2]}}, shift_in[2*W+2:2]};
        a_next    = shift_out[2*W+2:W+1];
        q_next    = shift_out[W:1];
        qm1_next  = shift_out[0];
    end

    // Restoring division on magnitudes; q shifts the dividend out and quotient bits in.
    logic [W:0]   div_shift;
    logic         div_ok;
    logic [W-1:0] rem_next, quo_next;

    always_comb begin
        div_shift = {rem, q[W-1]};
        div_ok    = div_shift >= {1'b0, m};
        rem_next  = div_ok ? W'(div_shift - {1'b0, m}) : W'(div_shift);
        quo_next  = {q[W-2:0], div_ok};
    end

    logic [W-1:0] r_addsub, x_mag, y_mag, quo_s, rem_s;
    logic         ovf, div_ovf;

    always_comb begin
        r_addsub = opc[0] ? (x - y) : (x + y);
        if (opc[0])
            ovf = (x[W-1] != y[W-1]) && (r_addsub[W-1] != x[W-1]);
        else
            ovf = (x[W-1] == y[W-1]) && (r_addsub[W-1] != x[W-1]);
        x_mag   = x[W-1] ? -x : x;
        y_mag   = bus.inbus[W-1] ? -bus.inbus : bus.inbus;
        quo_s   = (x[W-1] ^ y[W-1]) ? -q : q;
        rem_s   = x[W-1] ? -rem : rem;
        div_ovf = (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opc      <= '0;
            x        <= '0;
            y        <= '0;
            m        <= '0;
            q        <= '0;
            rem      <= '0;
            res_lo   <= '0;
            a        <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            outbus_r <= '0;
            valid_r  <= 1'b0;
            end_r    <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            outbus_r <= '0;
            valid_r  <= 1'b0;
            end_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.BEGIN) begin
                        opc     <= bus.op_code;
                        error_r <= 1'b0;
                        state   <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    x     <= bus.inbus;
                    state <= LOAD_Y;
                end
                LOAD_Y: begin
                    y   <= bus.inbus;
                    cnt <= '0;
                    case (opc)
                        2'b10: begin
                            a     <= '0;
                            q     <= x;
                            q_m1  <= 1'b0;
                            m     <= bus.inbus;
                            state <= MUL_STEP;
                        end
                        2'b11: begin
                            if (bus.inbus == '0) begin
                                outbus_r <= '1;
                                valid_r  <= 1'b1;
                                res_lo   <= x;
                                error_r  <= 1'b1;
                                state    <= OUT_HI;
                            end else begin
                                q     <= x_mag;
                                rem   <= '0;
                                m     <= y_mag;
                                state <= DIV_STEP;
                            end
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: begin
                    outbus_r <= r_addsub;
                    valid_r  <= 1'b1;
                    end_r    <= 1'b1;
                    error_r  <= ovf;
                    state    <= OUT_LO;
                end
                MUL_STEP: begin
                    a    <= a_next;
                    q    <= q_next;
                    q_m1 <= qm1_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W / 2 - 1)) begin
                        outbus_r <= a_next[W-1:0];
                        res_lo   <= q_next;
                        valid_r  <= 1'b1;
                        state    <= OUT_HI;
                    end
                end
                DIV_STEP: begin
                    q   <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1))
                        state <= DIV_FIX;
                end
                DIV_FIX: begin
                    outbus_r <= quo_s;
                    res_lo   <= rem_s;
                    valid_r  <= 1'b1;
                    error_r  <= div_ovf;
                    state    <= OUT_HI;
                end
                OUT_HI: begin
                    outbus_r <= res_lo;
                    valid_r  <= 1'b1;
                    end_r    <= 1'b1;
                    state    <= OUT_LO;
                end
                OUT_LO:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.outbus       = outbus_r;
    assign bus.outbus_valid = valid_r;
    assign bus.END          = end_r;
    assign bus.error        = error_r;
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param: a driver issues operations, a reference model queues the
// expected words with their cycle, and a monitor pops and compares each output word.
module tb_alu_param;
    localparam int W  = 8;
    localparam int EW = W + 2;
    localparam longint MINV = -(longint'(1) << (W - 1));
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    alu_param_if #(.W(W)) bus ();
    alu_param #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: words are {data, END, error} with their absolute cycle
    task automatic push_exp(input logic [1:0] op, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input int t0, output int last);
        longint xs, ys, r, qv, rv;
        logic [2*W-1:0] p;
        logic err;
        int lat;
        xs = longint'($signed(xv));
        ys = longint'($signed(yv));
        case (op)
            2'd0, 2'd1: begin
                r   = (op == 2'd0) ? xs + ys : xs - ys;
                err = (r > MAXV) || (r < MINV);
                p   = r[2*W-1:0];
                exp_q.push_back({p[W-1:0], 1'b1, err});
                exp_cyc_q.push_back(t0 + 4);
                last = t0 + 4;
            end
            2'd2: begin
                r = xs * ys;
                p = r[2*W-1:0];
                exp_q.push_back({p[2*W-1:W], 1'b0, 1'b0});
                exp_cyc_q.push_back(t0 + 3 + W / 2);
                exp_q.push_back({p[W-1:0], 1'b1, 1'b0});
                exp_cyc_q.push_back(t0 + 4 + W / 2);
                last = t0 + 4 + W / 2;
            end
            default: begin
                if (ys == 0) begin
                    qv = -1; rv = xs; err = 1'b1; lat = 3;
                end else if (xs == MINV && ys == -1) begin
                    qv = MINV; rv = 0; err = 1'b1; lat = 4 + W;
                end else begin
                    qv = xs / ys; rv = xs % ys; err = 1'b0; lat = 4 + W;
                end
                exp_q.push_back({qv[W-1:0], 1'b0, err});
                exp_cyc_q.push_back(t0 + lat);
                exp_q.push_back({rv[W-1:0], 1'b1, err});
                exp_cyc_q.push_back(t0 + lat + 1);
                last = t0 + lat + 1;
            end
        endcase
    endtask

    // driver tasks
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input bit hold);
        int t0, last;
        @(negedge clk);
        bus.BEGIN   = 1'b1;
        bus.op_code = op;
        bus.inbus   = W'($urandom);
        t0 = cyc;
        push_exp(op, xv, yv, t0, last);
        @(negedge clk);
        bus.BEGIN   = hold;
        bus.op_code = 2'($urandom);
        bus.inbus   = xv;
        @(negedge clk);
        bus.BEGIN   = hold;
        bus.op_code = 2'($urandom);
        bus.inbus   = yv;
        while (cyc < last) begin
            @(negedge clk);
            bus.BEGIN   = hold;
            bus.op_code = 2'($urandom);
            bus.inbus   = W'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.BEGIN = 1'b0;
            bus.inbus = W'($urandom);
        end
    endtask

    task automatic abort_mul(input logic [W-1:0] xv, input logic [W-1:0] yv);
        int t0;
        @(negedge clk);
        bus.BEGIN   = 1'b1;
        bus.op_code = 2'b10;
        t0 = cyc;
        @(negedge clk);
        bus.BEGIN = 1'b0;
        bus.inbus = xv;
        @(negedge clk);
        bus.inbus = yv;
        while (cyc < t0 + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", 32'(bus.fsm_state), 32'd0);
        check("abort_outputs", {bus.outbus, bus.outbus_valid, bus.END, bus.error}, '0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = {1'b1, {(W-1){1'b0}}};
            2:       v = '1;
            3:       v = W'(1);
            4:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            ec;
        if (mon_en) begin
            if (bus.outbus_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h END=%0b, expected no output (cycle %0d)",
                             bus.outbus, bus.END, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("word{data,end,err}", {bus.outbus, bus.END, bus.error}, e);
                    check("word_cycle", cyc, ec);
                end
            end else begin
                check("idle_bus", {bus.outbus, bus.END}, '0);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.BEGIN   = 1'b0;
        bus.op_code = 2'b00;
        bus.inbus   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.outbus, bus.outbus_valid, bus.END, bus.error}, '0);
        check("reset_state", 32'(bus.fsm_state), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        do_op(2'b00, 8'd100, 8'd50, 1'b0);
        do_op(2'b01, 8'd5, 8'd7, 1'b0);
        do_op(2'b10, 8'hF9, 8'd13, 1'b0);
        do_op(2'b10, 8'h80, 8'h80, 1'b0);
        do_op(2'b11, 8'h9C, 8'd7, 1'b0);
        do_op(2'b11, 8'd100, 8'hF9, 1'b0);
        do_op(2'b11, 8'h25, 8'h00, 1'b0);
        do_op(2'b11, 8'h80, 8'hFF, 1'b0);
        idle(2);

        abort_mul(8'hF9, 8'd13);
        idle(6);
        do_op(2'b00, 8'd3, 8'hFC, 1'b0);

        do_op(2'b11, 8'h9C, 8'd7, 1'b1);
        do_op(2'b01, 8'h80, 8'd1, 1'b0);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(30);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
